// File: rtl/bus_step_sequencer_pkg.sv
// Shared definitions for the bus step sequencer: state encoding, opcodes,
// bus source indices and instruction-register field positions.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_DONE = 3'd7
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  function automatic logic is_rr(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/bus_step_sequencer_reg_index_decoder.sv
// 4-bit register index to 16-bit one-hot select.
module reg_index_decoder (
  input  logic [3:0]  idx_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/bus_step_sequencer.sv
// T0..T5 bus step sequencer; only driver of the datapath bus source selects.
// Optional memory-wait timeout in T1 is compiled in with MEM_WAIT_TIMEOUT_EN.
import bus_ctrl_pkg::*;

module bus_step_sequencer
`ifdef MEM_WAIT_TIMEOUT_EN
  #(parameter int MEM_WAIT_LIMIT = 16)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir_val,
  input  logic        mem_ready,
  output logic [23:0] src_sel,
  output logic [15:0] r_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        y_in,
  output logic        z_in,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d, st;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc, sel_idx;
  logic [15:0] sel_oh, ra_oh;
  logic        tmo;
  logic        unused_ir;

  assign op        = ir_val[IR_OP_MSB:IR_OP_LSB];
  assign ra        = ir_val[IR_RA_LSB +: 4];
  assign rb        = ir_val[IR_RB_LSB +: 4];
  assign rc        = ir_val[IR_RC_LSB +: 4];
  assign unused_ir = ^ir_val[IR_RC_LSB-1:0];

  // Reset forces the decode to IDLE so no strobe, done or err leaks out while aborting.
  assign st      = reset ? S_IDLE : state_q;
  assign sel_idx = (st == S_T4) ? rc : rb;

  reg_index_decoder u_sel_dec (.idx_i(sel_idx), .onehot_o(sel_oh));
  reg_index_decoder u_ra_dec  (.idx_i(ra),      .onehot_o(ra_oh));

`ifdef MEM_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(MEM_WAIT_LIMIT + 1);
  logic [CW-1:0] wcnt_q, wcnt_d;

  assign tmo = (st == S_T1) && (wcnt_q == CW'(MEM_WAIT_LIMIT));

  always_comb begin
    wcnt_d = wcnt_q;
    if (st == S_T0)
      wcnt_d = '0;
    else if ((st == S_T1) && !mem_ready)
      wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = st;
    src_sel = '0;
    r_in    = '0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    pc_in   = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    ir_in   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    alu_op  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (st)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        busy = 1'b1; src_sel[SRC_PC] = 1'b1;
        mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        busy = 1'b1;
        if (tmo) begin
          err = 1'b1; state_d = S_IDLE;
        end else begin
          src_sel[SRC_ZLO] = 1'b1;
          pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
          if (mem_ready) state_d = S_T2;
        end
      end
      S_T2: begin
        busy = 1'b1; src_sel[SRC_MDR] = 1'b1; ir_in = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_rr(op) || is_imm(op)) begin
          src_sel[15:0] = sel_oh; y_in = 1'b1; state_d = S_T4;
        end else if (op == OP_MFHI) begin
          src_sel[SRC_HI] = 1'b1; r_in = ra_oh; state_d = S_DONE;
        end else if (op == OP_MFLO) begin
          src_sel[SRC_LO] = 1'b1; r_in = ra_oh; state_d = S_DONE;
        end else begin
          err = 1'b1; state_d = S_IDLE;
        end
      end
      S_T4: begin
        busy = 1'b1;
        if (is_imm(op)) src_sel[SRC_C] = 1'b1;
        else            src_sel[15:0]  = sel_oh;
        alu_op = op; z_in = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        busy = 1'b1; src_sel[SRC_ZLO] = 1'b1; r_in = ra_oh;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_bus_step_sequencer.sv
// Directed bench for bus_step_sequencer; all outputs packed into one vector per cycle.
module tb_bus_step_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [31:0] ir_val;
  logic [23:0] src_sel;
  logic [15:0] r_in;
  logic        hi_in, lo_in, y_in, z_in, pc_in, mar_in, mdr_in, ir_in, inc_pc, read;
  logic [4:0]  alu_op;
  logic        busy, done, err;
  logic [63:0] obs;
  int          passed = 0;
  int          total  = 0;

  // strobe packing: {hi,lo,y,z,pc,mar,mdr,ir,inc_pc,read}
  localparam logic [9:0] B_T0 = 10'h052;
  localparam logic [9:0] B_T1 = 10'h029;
  localparam logic [9:0] B_T2 = 10'h004;
  localparam logic [9:0] B_Y  = 10'h080;
  localparam logic [9:0] B_Z  = 10'h040;

  always #5 clk = ~clk;

`ifdef MEM_WAIT_TIMEOUT_EN
  bus_step_sequencer #(.MEM_WAIT_LIMIT(4)) dut (
`else
  bus_step_sequencer dut (
`endif
    .clk(clk), .reset(reset), .start(start), .ir_val(ir_val), .mem_ready(mem_ready),
    .src_sel(src_sel), .r_in(r_in), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in),
    .z_in(z_in), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
    .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  assign obs = {6'b0, src_sel, r_in, hi_in, lo_in, y_in, z_in, pc_in, mar_in, mdr_in,
                ir_in, inc_pc, read, alu_op, busy, done, err};

  function automatic logic [23:0] sb(input int i);
    logic [23:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] ex(input logic [23:0] s, input logic [15:0] r,
                                     input logic [9:0] b, input logic [4:0] a,
                                     input logic bz, input logic d, input logic er);
    return {6'b0, s, r, b, a, bz, d, er};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fetch();
    chk("T0", ex(sb(20), 16'h0, B_T0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("T1", ex(sb(19), 16'h0, B_T1, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("T2", ex(sb(21), 16'h0, B_T2, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
  endtask

  localparam logic [63:0] E_IDLE = 64'h0;
  localparam logic [63:0] E_DONE = 64'h2;
  localparam logic [63:0] E_ERR  = 64'h5;

  initial begin
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1;
    ir_val = mk_ir(5'b00011, 4'd3, 4'd5, 4'd7);
    tick(); chk("rst0", E_IDLE);
    tick(); chk("rst1", E_IDLE);
    reset = 1'b0;
    go();
    // ADD R3 = R5 + R7
    fetch();
    chk("add_T3", ex(sb(5),  16'h0,    B_Y, 5'd0,     1'b1, 1'b0, 1'b0)); tick();
    chk("add_T4", ex(sb(7),  16'h0,    B_Z, 5'b00011, 1'b1, 1'b0, 1'b0)); tick();
    chk("add_T5", ex(sb(19), 16'h0008, '0,  5'd0,     1'b1, 1'b0, 1'b0)); tick();
    chk("add_DONE", E_DONE);
    start = 1'b1;
    ir_val = mk_ir(5'b01110, 4'd2, 4'd4, 4'd0);
    tick(); chk("gap_IDLE", E_IDLE);
    go();
    // ORI R2 = R4 | C, started back-to-back
    fetch();
    chk("ori_T3", ex(sb(4),  16'h0,    B_Y, 5'd0,     1'b1, 1'b0, 1'b0)); tick();
    chk("ori_T4", ex(sb(23), 16'h0,    B_Z, 5'b01110, 1'b1, 1'b0, 1'b0)); tick();
    chk("ori_T5", ex(sb(19), 16'h0004, '0,  5'd0,     1'b1, 1'b0, 1'b0)); tick();
    chk("ori_DONE", E_DONE); tick();
    chk("ori_IDLE", E_IDLE);
    // MFLO R9
    ir_val = mk_ir(5'b11001, 4'd9, 4'd1, 4'd2);
    go(); fetch();
    chk("mflo_T3", ex(sb(17), 16'h0200, '0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mflo_DONE", E_DONE); tick();
    chk("mflo_IDLE", E_IDLE);
    // MFHI R0
    ir_val = mk_ir(5'b11000, 4'd0, 4'd0, 4'd0);
    go(); fetch();
    chk("mfhi_T3", ex(sb(16), 16'h0001, '0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mfhi_DONE", E_DONE); tick();
    // illegal opcode
    ir_val = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    go(); fetch();
    chk("ill_T3", E_ERR | 64'h4); tick();
    chk("ill_IDLE", E_IDLE); tick();
    chk("ill_IDLE2", E_IDLE);
    // memory wait: 5 cycles of mem_ready low, read held for 6
    ir_val = mk_ir(5'b00011, 4'd1, 4'd1, 4'd1);
    mem_ready = 1'b0;
    go();
    chk("mw_T0", ex(sb(20), 16'h0, B_T0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    for (int k = 0; k < 5; k++) begin
      chk("mw_T1", ex(sb(19), 16'h0, B_T1, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    end
    mem_ready = 1'b1;
    chk("mw_T1last", ex(sb(19), 16'h0, B_T1, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mw_T2", ex(sb(21), 16'h0, B_T2, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mw_T3", ex(sb(1),  16'h0, B_Y,  5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mw_T4", ex(sb(1),  16'h0, B_Z,  5'b00011, 1'b1, 1'b0, 1'b0)); tick();
    chk("mw_T5", ex(sb(19), 16'h0002, '0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    chk("mw_DONE", E_DONE); tick();
    // reset mid-sequence with an illegal opcode in T3: no err, no done
    ir_val = mk_ir(5'b11111, 4'd0, 4'd0, 4'd0);
    go(); fetch();
    reset = 1'b1; #1;
    chk("abort_T3", E_IDLE); tick();
    chk("abort_rst", E_IDLE);
    reset = 1'b0; tick();
    chk("abort_IDLE", E_IDLE);
    // mem_ready stuck low
    ir_val = mk_ir(5'b00011, 4'd1, 4'd1, 4'd1);
    mem_ready = 1'b0;
    go();
    chk("stk_T0", ex(sb(20), 16'h0, B_T0, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
`ifdef MEM_WAIT_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      chk("tmo_T1", ex(sb(19), 16'h0, B_T1, 5'd0, 1'b1, 1'b0, 1'b0)); tick();
    end
    chk("tmo_err", E_ERR | 64'h4); tick();
    chk("tmo_IDLE", E_IDLE);
`else
    for (int k = 0; k < 100; k++) tick();
    chk("stk_T1_100", ex(sb(19), 16'h0, B_T1, 5'd0, 1'b1, 1'b0, 1'b0));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("stk_IDLE", E_IDLE);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
